bench_pin_driver: RTL and testbench
===================================

Name: bench_pin_driver

Overview:
- Tester-side counterpart of the 8-pin benchmark wrapper.
- The wrapper consumes an 8-bit pin bus: bit 0 = DUT clock, bit 1 = DUT active-low reset, bits 7:5 = output select, bits 4:2 = stimulus. It returns an 8-bit result bus.
- This block drives that pin bus from a system clock. It generates the DUT clock and reset, runs a commanded number of DUT cycles, and samples the DUT output each cycle.
- It returns the last sample and a 16-bit rolling signature over a valid/ready response channel.
- It sits in the FPGA bring-up harness between the host command path and the chip pins.

Parameters:
- HALF_PERIOD, 2: system clocks per DUT clock phase (high phase and low phase each); minimum 1.
- RESET_CYCLES, 2: DUT clock periods during which the DUT reset is held low when a command requests reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_sel  in  3  DUT output select, driven to pin_out[7:5].
- cmd_stim  in  3  DUT stimulus, driven to pin_out[4:2].
- cmd_cycles  in  8  number of DUT rising edges to run (0..255).
- cmd_reset  in  1  1 = run a DUT reset phase before the run.
- pin_out  out  8  to DUT pin input bus.
- pin_in  in  8  from DUT pin output bus; quasi-static.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  host accepts result.
- rsp_data  out  8  last sampled pin_in.
- rsp_sig  out  16  rolling signature of all samples in the run.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n low): state=IDLE, pin_out=8'h00 (DUT clock low, DUT reset asserted), rsp_valid=0, rsp_data=8'h00, rsp_sig=16'h0000, busy=0, cmd_ready=1 after release.
- All outputs are registered.
- States: IDLE, RST, RUN, RESP.
- IDLE:
  - pin_out[0]=0; other pin_out bits hold their last values.
  - Command accepted on the edge where cmd_valid & cmd_ready (edge t0).
  - At t0: pin_out[7:5]<=cmd_sel, pin_out[4:2]<=cmd_stim, pin_out[1]<=~cmd_reset.
  - At t0: cycle counter<=cmd_cycles, phase counter<=0, signature<=16'h0000, rsp_data<=8'h00.
  - Next state: RST if cmd_reset, else RUN.
- DUT clock generation (RST and RUN):
  - pin_out[0] high for HALF_PERIOD system clocks, then low for HALF_PERIOD.
  - The first system cycle after t0 (or after a phase transition) begins a high phase.
  - One DUT period = 2*HALF_PERIOD system clocks.
- RST:
  - Runs RESET_CYCLES full DUT periods with pin_out[1]=0.
  - On the edge ending the last low phase: pin_out[1]<=1, go to RUN. No samples are taken in RST.
- RUN:
  - Executes cmd_cycles DUT periods.
  - On the system edge ending each low phase: rsp_data<=pin_in and sig<={sig[14:0],sig[15]} ^ {8'h00,pin_in}. The signature is rotate-left-by-1 then XOR the sample into the low byte.
  - After the final period's sample edge, go to RESP.
  - If cmd_cycles=0: go to RESP on the first edge after t0. No DUT edge occurs, rsp_data=8'h00, rsp_sig=16'h0000.
- Latency: rsp_valid rises L system cycles after t0, where L = (cmd_reset ? RESET_CYCLES*2*HALF_PERIOD : 0) + cmd_cycles*2*HALF_PERIOD, with a minimum of 1.
- RESP:
  - rsp_valid=1; rsp_data and rsp_sig are stable.
  - pin_out[0]=0; pin_out[7:1] hold.
  - On rsp_valid & rsp_ready: rsp_valid<=0, go to IDLE. cmd_ready rises on that same edge, so a new command is accepted no earlier than the next edge.
- While busy: cmd_valid is ignored (cmd_ready=0), and cmd_* changes do not affect pin_out.
- Reset mid-run: pin_out goes immediately to 8'h00 and any pending response is discarded.
- Counters:
  - Cycle counter is 8 bits, decremented per completed period; it never wraps.
  - Phase counter is sized for 2*HALF_PERIOD.
- pin_out[1] stays at its last value across commands without cmd_reset, so a run without reset continues DUT state.

Test Plan:
1. Power-on reset, then release with no command -> pin_out=8'h00, cmd_ready=1, busy=0, rsp_valid=0.
2. cmd_sel=3'b101, cmd_stim=3'b010, cmd_reset=1, cmd_cycles=4, HALF_PERIOD=2, RESET_CYCLES=2 -> pin_out[7:2]=6'b101010 from t0.
   - pin_out[1]=0 for 8 cycles, then 1.
   - 4 clock pulses of 2 high / 2 low.
   - rsp_valid rises exactly 24 cycles after t0.
3. pin_in held at 8'hA5, cmd_cycles=3, cmd_reset=0 -> rsp_data=8'hA5, rsp_sig=16'h037B. The intermediate values are 00A5 and then 01EF. pin_out[1] is unchanged.
4. cmd_cycles=0 -> rsp_valid one cycle after t0, rsp_data=8'h00, rsp_sig=16'h0000, and pin_out[0] never rises.
5. Response backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_data and rsp_sig stable, cmd_ready=0, a cmd_valid pulse is ignored. Then rsp_ready=1 -> IDLE next edge.
6. Assert reset_n mid-RUN during a DUT high phase -> pin_out=8'h00 immediately (asynchronously), rsp_valid=0. After release, a new command runs normally with the signature starting from 0.

Source files
------------

// File: rtl/bench_pin_driver.sv
// Tester-side pin driver for the 8-pin benchmark wrapper.
// Generates the DUT clock and active-low reset on pin_out[1:0], drives select
// and stimulus on pin_out[7:2], samples pin_in once per DUT period and returns
// the last sample plus a 16-bit rotate/XOR signature over a valid/ready channel.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command, DUT clock parked low
// RST    | clocking the DUT with its reset held low for RESET_CYCLES periods
// RUN    | clocking the DUT for cmd_cycles periods, sampling at each period end
// RESP   | result presented on rsp_*, DUT clock parked low
module bench_pin_driver #(
  parameter int HALF_PERIOD  = 2,
  parameter int RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_sel,
  input  logic [2:0]  cmd_stim,
  input  logic [7:0]  cmd_cycles,
  input  logic        cmd_reset,
  output logic [7:0]  pin_out,
  input  logic [7:0]  pin_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [15:0] rsp_sig,
  output logic        busy
);

  // Phase counter counts down from 2*HALF_PERIOD-1; the DUT clock is high
  // while the remaining count is at least HALF_PERIOD.
  localparam int PW = $clog2(2 * HALF_PERIOD);
  localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PH_LOAD = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(HALF_PERIOD);
  localparam logic [RW-1:0] RC_LOAD = RW'(RESET_CYCLES);
  localparam logic          HAS_RST = (RESET_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RST  = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    pin_q, pin_d;
  logic [7:0]    cyc_q, cyc_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [RW-1:0] rc_q, rc_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [15:0]   sig_q, sig_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;

  logic [PW-1:0] ph_dec;
  logic          ph_tc;
  logic          rc_last;
  logic          cyc_last;
  logic [15:0]   sig_next;

  assign ph_dec   = ph_q - PW'(1);
  assign ph_tc    = (ph_q == '0);
  assign rc_last  = (rc_q == RW'(1));
  assign cyc_last = (cyc_q == 8'd1);
  assign sig_next = {sig_q[14:0], sig_q[15]} ^ {8'h00, pin_in};

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pin_d       = pin_q;
    cyc_d       = cyc_q;
    ph_d        = ph_q;
    rc_d        = rc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    sig_d       = sig_q;

    case (state_q)
      S_IDLE: begin
        pin_d[0] = 1'b0;
        if (cmd_valid && cmd_ready_q) begin
          pin_d[7:5] = cmd_sel;
          pin_d[4:2] = cmd_stim;
          cyc_d      = cmd_cycles;
          ph_d       = PH_LOAD;
          rc_d       = RC_LOAD;
          sig_d      = 16'h0000;
          rsp_data_d = 8'h00;
          if (HAS_RST && cmd_reset) begin
            pin_d[1] = 1'b0;
            pin_d[0] = 1'b1;
            state_d  = S_RST;
          end else begin
            pin_d[1] = 1'b1;
            // A zero-length run never produces a DUT edge.
            pin_d[0] = (cmd_cycles != 8'd0);
            state_d  = S_RUN;
          end
        end
      end

      S_RST: begin
        if (ph_tc) begin
          ph_d = PH_LOAD;
          if (rc_last) begin
            pin_d[1] = 1'b1;
            if (cyc_q == 8'd0) begin
              pin_d[0]    = 1'b0;
              rsp_valid_d = 1'b1;
              state_d     = S_RESP;
            end else begin
              pin_d[0] = 1'b1;
              state_d  = S_RUN;
            end
          end else begin
            rc_d     = rc_q - RW'(1);
            pin_d[0] = 1'b1;
          end
        end else begin
          ph_d     = ph_dec;
          pin_d[0] = (ph_dec >= PH_HI);
        end
      end

      S_RUN: begin
        if (cyc_q == 8'd0) begin
          pin_d[0]    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (ph_tc) begin
          rsp_data_d = pin_in;
          sig_d      = sig_next;
          cyc_d      = cyc_q - 8'd1;
          if (cyc_last) begin
            pin_d[0]    = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            ph_d     = PH_LOAD;
            pin_d[0] = 1'b1;
          end
        end else begin
          ph_d     = ph_dec;
          pin_d[0] = (ph_dec >= PH_HI);
        end
      end

      S_RESP: begin
        pin_d[0] = 1'b0;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        pin_d[0]    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset parks the DUT in reset with its clock low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pin_q       <= 8'h00;
      cyc_q       <= 8'h00;
      ph_q        <= '0;
      rc_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      sig_q       <= 16'h0000;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      cyc_q       <= cyc_d;
      ph_q        <= ph_d;
      rc_q        <= rc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sig_q       <= sig_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign pin_out   = pin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sig   = sig_q;
  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bench_pin_driver.sv
// Testbench for bench_pin_driver: table of directed commands with hand-derived
// results, randomized commands against a per-cycle behavioural model, and a
// mid-run asynchronous reset sequence.
module tb_bench_pin_driver;

  localparam int HP = 2;
  localparam int RC = 2;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sel;
  logic [2:0]  cmd_stim;
  logic [7:0]  cmd_cycles;
  logic        cmd_reset;
  logic [7:0]  pin_out;
  logic [7:0]  pin_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [15:0] rsp_sig;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // pin_in value presented during each DUT period of a run
  logic [7:0] pv [0:255];

  bench_pin_driver #(.HALF_PERIOD(HP), .RESET_CYCLES(RC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_sel    (cmd_sel),
    .cmd_stim   (cmd_stim),
    .cmd_cycles (cmd_cycles),
    .cmd_reset  (cmd_reset),
    .pin_out    (pin_out),
    .pin_in     (pin_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_sig    (rsp_sig),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it cycle by cycle through to IDLE.
  // k counts system edges after the accepting edge t0.
  task automatic run_cmd(input logic [2:0] sel, input logic [2:0] stim,
                         input logic [7:0] cyc, input bit rst, input int hold,
                         output int lat, output logic [7:0] dat, output logic [15:0] sig);
    int P, R, N, L, j;
    logic [15:0] msig;
    logic [7:0]  mdat;
    logic        e0, e1;
    logic [7:0]  epin;
    P    = 2 * HP;
    R    = rst ? RC * P : 0;
    N    = int'(cyc) * P;
    L    = (R + N > 0) ? R + N : 1;
    msig = 16'h0000;
    mdat = 8'h00;
    lat  = -1;
    chk("pre cmd_ready", 32'(cmd_ready), 32'd1);
    chk("pre busy", 32'(busy), 32'd0);
    cmd_sel    = sel;
    cmd_stim   = stim;
    cmd_cycles = cyc;
    cmd_reset  = rst;
    cmd_valid  = 1'b1;
    pin_in     = pv[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k <= L; k++) begin
      if (k > R && ((k - R) % P) == 0) begin
        j = (k - R) / P;
        if (j >= 1 && j <= int'(cyc)) begin
          mdat = pv[j-1];
          msig = {msig[14:0], msig[15]} ^ {8'h00, pv[j-1]};
        end
      end
      if (k == L)     e0 = 1'b0;
      else if (k < R) e0 = ((k % P) < HP);
      else            e0 = ((k - R) < N) && (((k - R) % P) < HP);
      e1   = rst ? (k >= R) : 1'b1;
      epin = {sel, stim, e1, e0};
      chk($sformatf("pin_out k=%0d", k), 32'(pin_out), 32'(epin));
      chk($sformatf("rsp_valid k=%0d", k), 32'(rsp_valid), 32'(k == L));
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
      chk($sformatf("cmd_ready k=%0d", k), 32'(cmd_ready), 32'd0);
      chk($sformatf("rsp_sig k=%0d", k), 32'(rsp_sig), 32'(msig));
      chk($sformatf("rsp_data k=%0d", k), 32'(rsp_data), 32'(mdat));
      if (rsp_valid === 1'b1 && lat < 0) lat = k;
      if (k >= R) begin
        j = (k - R) / P;
        if (j < 256) pin_in = pv[j];
      end
      if (k < L) begin
        @(posedge clk); #1;
      end
    end
    dat  = rsp_data;
    sig  = rsp_sig;
    epin = {sel, stim, 1'b1, 1'b0};
    // Backpressure with a stray command that must be ignored.
    for (int h = 0; h < hold; h++) begin
      rsp_ready  = 1'b0;
      cmd_valid  = 1'b1;
      cmd_sel    = 3'($urandom);
      cmd_stim   = 3'($urandom);
      cmd_cycles = 8'($urandom_range(1, 9));
      cmd_reset  = 1'($urandom);
      pin_in     = 8'($urandom);
      @(posedge clk); #1;
      chk($sformatf("hold%0d rsp_valid", h), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold%0d pin_out", h), 32'(pin_out), 32'(epin));
      chk($sformatf("hold%0d rsp_data", h), 32'(rsp_data), 32'(mdat));
      chk($sformatf("hold%0d rsp_sig", h), 32'(rsp_sig), 32'(msig));
      chk($sformatf("hold%0d cmd_ready", h), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("release rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release busy", 32'(busy), 32'd0);
    chk("release cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release pin_out", 32'(pin_out), 32'(epin));
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [2:0]  stim;
    logic [7:0]  cyc;
    bit          rst;
    logic [7:0]  pval;
    int          hold;
    int          lat;
    logic [7:0]  dat;
    logic [15:0] sig;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int lat;
    logic [7:0]  d;
    logic [15:0] s;

    //          sel     stim    cyc   rst pval   hold lat dat    sig
    tbl[0] = '{3'b101, 3'b010, 8'd4, 1'b1, 8'h3C, 0,   24, 8'h3C, 16'h0154};
    tbl[1] = '{3'b101, 3'b010, 8'd3, 1'b0, 8'hA5, 10,  12, 8'hA5, 16'h037B};
    tbl[2] = '{3'b011, 3'b110, 8'd0, 1'b0, 8'h77, 1,   1,  8'h00, 16'h0000};
    tbl[3] = '{3'b000, 3'b111, 8'd0, 1'b1, 8'h5A, 0,   8,  8'h00, 16'h0000};
    tbl[4] = '{3'b111, 3'b001, 8'd1, 1'b0, 8'hFF, 2,   4,  8'hFF, 16'h00FF};
    tbl[5] = '{3'b010, 3'b100, 8'd2, 1'b1, 8'h80, 0,   16, 8'h80, 16'h0180};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_sel    = 3'd0;
    cmd_stim   = 3'd0;
    cmd_cycles = 8'd0;
    cmd_reset  = 1'b0;
    pin_in     = 8'h00;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("in reset pin_out", 32'(pin_out), 32'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("por pin_out", 32'(pin_out), 32'h00);
    chk("por cmd_ready", 32'(cmd_ready), 32'd1);
    chk("por busy", 32'(busy), 32'd0);
    chk("por rsp_valid", 32'(rsp_valid), 32'd0);
    chk("por rsp_data", 32'(rsp_data), 32'h00);
    chk("por rsp_sig", 32'(rsp_sig), 32'h0000);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 256; j++) pv[j] = tbl[i].pval;
      run_cmd(tbl[i].sel, tbl[i].stim, tbl[i].cyc, tbl[i].rst, tbl[i].hold, lat, d, s);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d rsp_data", i), 32'(d), 32'(tbl[i].dat));
      chk($sformatf("vec%0d rsp_sig", i), 32'(s), 32'(tbl[i].sig));
    end

    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 256; j++) pv[j] = 8'($urandom);
      run_cmd(3'($urandom), 3'($urandom), 8'($urandom_range(0, 10)),
              1'($urandom), $urandom_range(0, 3), lat, d, s);
    end

    // Asynchronous reset during a DUT high phase of a run.
    for (int j = 0; j < 256; j++) pv[j] = 8'h3C;
    pin_in     = 8'h3C;
    cmd_sel    = 3'b110;
    cmd_stim   = 3'b011;
    cmd_cycles = 8'd5;
    cmd_reset  = 1'b0;
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrun clk high", 32'(pin_out[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async pin_out", 32'(pin_out), 32'h00);
    chk("async rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async rsp_sig", 32'(rsp_sig), 32'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("after reset cmd_ready", 32'(cmd_ready), 32'd1);
    for (int j = 0; j < 256; j++) pv[j] = 8'($urandom);
    run_cmd(3'b001, 3'b101, 8'd5, 1'b0, 1, lat, d, s);
    chk("after reset latency", 32'(lat), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
